// File: rtl/wb_pkg.sv
// Shared definitions for the auto-white-balance gain controller.
// Color codes, unity gain and the sequencing FSM states.
package wb_pkg;

  localparam logic [1:0] RED   = 2'd0;
  localparam logic [1:0] GREEN = 2'd1;
  localparam logic [1:0] BLUE  = 2'd2;

  localparam logic [7:0] GAIN_ONE = 8'd64;

  typedef enum logic [1:0] {
    IDLE,
    DIV_R,
    DIV_B,
    UPDATE
  } state_t;

endpackage

// File: rtl/wb_gain_ctrl_if.sv
// Pixel stream as seen by the WB stage and its gain controller.
// The controller only observes, so the slave side is all inputs.
interface wb_gain_ctrl_if;

  logic       frame_start_i;
  logic       frame_end_i;
  logic       valid_i;
  logic [1:0] color_i;
  logic [7:0] value_i;

  modport master (
    output frame_start_i,
    output frame_end_i,
    output valid_i,
    output color_i,
    output value_i
  );

  modport slave (
    input frame_start_i,
    input frame_end_i,
    input valid_i,
    input color_i,
    input value_i
  );

endinterface

// File: rtl/seq_div.sv
// Restoring divider, one quotient bit per cycle, DW cycles total.
// The first bit is resolved on the start edge itself.
module seq_div #(
  parameter int DW = 30,
  parameter int VW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic          done,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW + 1);

  logic [DW-1:0] dd_q;
  logic [DW-1:0] dd_in;
  logic [DW-1:0] dd_nx;
  logic [VW-1:0] rem_q;
  logic [VW-1:0] rem_in;
  logic [VW-1:0] rem_nx;
  logic [VW-1:0] dv_q;
  logic [VW-1:0] dv_in;
  logic [VW:0]   trial;
  logic [VW:0]   diff;
  logic          ge;
  logic [CW-1:0] cnt_q;
  logic          act_q;

  // Quotient bits shift in at the bottom as dividend bits leave the top.
  always_comb begin
    dd_in  = start ? dividend : dd_q;
    rem_in = start ? '0 : rem_q;
    dv_in  = start ? divisor : dv_q;
    trial  = {rem_in, dd_in[DW-1]};
    diff   = trial - {1'b0, dv_in};
    ge     = (trial >= {1'b0, dv_in});
    rem_nx = ge ? diff[VW-1:0] : trial[VW-1:0];
    dd_nx  = {dd_in[DW-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dd_q  <= '0;
      rem_q <= '0;
      dv_q  <= '0;
      cnt_q <= '0;
      act_q <= 1'b0;
    end else if (start) begin
      dd_q  <= dd_nx;
      rem_q <= rem_nx;
      dv_q  <= dv_in;
      cnt_q <= CW'(DW - 1);
      act_q <= 1'b1;
    end else if (cnt_q != '0) begin
      dd_q  <= dd_nx;
      rem_q <= rem_nx;
      cnt_q <= cnt_q - CW'(1);
    end else begin
      act_q <= 1'b0;
    end
  end

  assign quotient    = dd_q;
  assign done        = act_q && (cnt_q == '0);
  assign div_by_zero = (dv_q == '0);

endmodule

// File: rtl/wb_gain_ctrl.sv
// Gray-world AWB controller: per-frame channel sums, shared divider,
// gains committed only from the UPDATE state (or manual passthrough).
module wb_gain_ctrl
  import wb_pkg::*;
#(
  parameter int SUM_W   = 24,
  parameter int FRAC    = 6,
  parameter int G_SHIFT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         auto_en,
  input  logic [7:0]   man_K_R,
  input  logic [7:0]   man_K_G,
  input  logic [7:0]   man_K_B,
  wb_gain_ctrl_if.slave pix,
  output logic [7:0]   K_R,
  output logic [7:0]   K_G,
  output logic [7:0]   K_B,
  output logic         upd_o,
  output logic         busy_o,
  output logic         err_o
);

  localparam int QW = SUM_W + FRAC;
  localparam logic [SUM_W-1:0] SMAX = '1;

  state_t state_q;
  state_t state_d;

  logic [SUM_W-1:0] sum_q [3];
  logic [SUM_W-1:0] sum_d [3];
  logic [SUM_W-1:0] base  [3];
  logic [SUM_W:0]   add   [3];
  logic             hit   [3];
  logic [SUM_W-1:0] g_now;
  logic [SUM_W-1:0] s_g_q;
  logic [SUM_W-1:0] s_b_q;

  logic             div_start;
  logic [QW-1:0]    div_dvd;
  logic [SUM_W-1:0] div_dvs;
  logic [QW-1:0]    div_q;
  logic             div_done;
  logic             div_zero;

  logic             snap;
  logic             cap_r;
  logic             do_upd;
  logic [7:0]       kr_new_q;
  logic             zr_q;

  function automatic logic [7:0] clamp(input logic [QW-1:0] q);
    return (|q[QW-1:8]) ? 8'hFF : q[7:0];
  endfunction

  // The pixel in a frame_start cycle lands in the freshly cleared sums.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      base[i]  = pix.frame_start_i ? '0 : sum_q[i];
      add[i]   = {1'b0, base[i]} + (SUM_W+1)'(pix.value_i);
      hit[i]   = pix.valid_i && (pix.color_i == 2'(i));
      sum_d[i] = !hit[i]    ? base[i] :
                 add[i][SUM_W] ? SMAX :
                 add[i][SUM_W-1:0];
    end
  end

  assign g_now = sum_d[GREEN] >> G_SHIFT;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      sum_q[i] <= rst ? '0 : sum_d[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    div_dvd   = {s_g_q, {FRAC{1'b0}}};
    div_dvs   = s_b_q;
    snap      = 1'b0;
    cap_r     = 1'b0;
    do_upd    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pix.frame_end_i) begin
          snap      = 1'b1;
          div_start = 1'b1;
          div_dvd   = {g_now, {FRAC{1'b0}}};
          div_dvs   = sum_d[RED];
          state_d   = DIV_R;
        end
      end
      DIV_R: begin
        if (div_done) begin
          cap_r     = 1'b1;
          div_start = 1'b1;
          state_d   = DIV_B;
        end
      end
      DIV_B: begin
        if (div_done) state_d = UPDATE;
      end
      UPDATE: begin
        do_upd  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  seq_div #(
    .DW (QW),
    .VW (SUM_W)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .start       (div_start),
    .dividend    (div_dvd),
    .divisor     (div_dvs),
    .quotient    (div_q),
    .done        (div_done),
    .div_by_zero (div_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s_g_q    <= '0;
      s_b_q    <= '0;
      kr_new_q <= '0;
      zr_q     <= 1'b0;
    end else begin
      if (snap) begin
        s_g_q <= g_now;
        s_b_q <= sum_d[BLUE];
      end
      if (cap_r) begin
        kr_new_q <= clamp(div_q);
        zr_q     <= div_zero;
      end
    end
  end

  // In UPDATE the divider still holds the blue result.
  always_ff @(posedge clk) begin
    if (rst) begin
      K_R   <= GAIN_ONE;
      K_G   <= GAIN_ONE;
      K_B   <= GAIN_ONE;
      upd_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      upd_o <= do_upd && auto_en;
      if (!auto_en) begin
        K_R <= man_K_R;
        K_G <= man_K_G;
        K_B <= man_K_B;
      end else if (do_upd) begin
        K_G <= GAIN_ONE;
        if (!zr_q)     K_R <= kr_new_q;
        if (!div_zero) K_B <= clamp(div_q);
      end
      if (do_upd && (zr_q || div_zero)) err_o <= 1'b1;
      else if (pix.frame_start_i)       err_o <= 1'b0;
    end
  end

  assign busy_o = (state_q == DIV_R) || (state_q == DIV_B);

endmodule

// File: doc/wb_gain_ctrl.md
Name: wb_gain_ctrl

Overview:
Auto-white-balance controller that sequences the WB gain stage.
- Monitors the same pixel stream that feeds WB (valid/color/value).
- Accumulates per-channel sums over a frame.
- At frame end, computes gray-world gains with a shared sequential divider.
- Drives K_R/K_G/K_B, updating them only at a defined cycle so gains never change mid-computation.
- Manual mode bypasses the computation and passes software gains through.

Parameters:
- SUM_W, 24: per-channel accumulator width. Accumulators saturate at 2^SUM_W-1.
- FRAC, 6: fractional bits of the gain format. Gains are unsigned Q(8-FRAC).FRAC, so 64 = 1.0.
- G_SHIFT, 0: right-shift applied to the G sum before division. Use 1 for Bayer, where G is 2x R/B.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- auto_en  in  1  1 = computed gains, 0 = manual gains
- man_K_R / man_K_G / man_K_B  in  8 each  manual gains
- frame_start_i  in  1  one-cycle pulse, first pixel of frame
- frame_end_i  in  1  one-cycle pulse, last pixel of frame
- valid_i  in  1  pixel valid
- color_i  in  2  0=R, 1=G, 2=B, 3=ignored
- value_i  in  8  pixel value
- K_R / K_G / K_B  out  8 each  registered gains to the WB stage
- upd_o  out  1  one-cycle pulse when K_* change from computation
- busy_o  out  1  high while dividing
- err_o  out  1  sticky; set on zero-divisor channel; cleared by rst or frame_start_i

Behaviour:
Reset
- rst=1 at a clock edge: all state cleared; state=IDLE.
- K_R=K_G=K_B=8'd64 (unity); upd_o=0, busy_o=0, err_o=0.
- Reset mid-division aborts the division with no update.

Accumulation (independent of FSM state)
- frame_start_i=1: sum_R/G/B are cleared. A valid pixel in the same cycle is added to the cleared sums (it belongs to the new frame).
- valid_i=1: sum[color_i] += value_i, saturating. color_i=3 is ignored.
- Pixel coincident with frame_end_i is included in the frame.

FSM states: IDLE, DIV_R, DIV_B, UPDATE.
- IDLE, frame_end_i=1:
  - snapshot S_G=(sum_G incl. current pixel)>>G_SHIFT, S_R, S_B;
  - go to DIV_R.
- DIV_R:
  - restoring divide, 1 quotient bit/cycle;
  - dividend = S_G<<FRAC, divisor = S_R;
  - QW = SUM_W+FRAC cycles, then DIV_B.
- DIV_B: same with divisor S_B; QW cycles, then UPDATE.
- UPDATE (1 cycle): results are written to registered outputs at the end of this cycle; upd_o=1 during that following cycle. Then return to IDLE.
- busy_o=1 in DIV_R and DIV_B.

Latency
- frame_end_i sampled at edge E.
- upd_o high and new K_* visible in cycle E+2*QW+1 (default QW=30 → 61 cycles).

Arithmetic
- Quotient is truncated, not rounded.
- Quotient >255 clamps to 255.
- K_G is always 64 in auto mode.
- Divisor=0: that channel keeps its previous gain; err_o is set. The other channel still updates, and upd_o still pulses.

Busy conflicts
- frame_end_i while busy: ignored; that frame produces no update. Accumulation of the following frame proceeds normally.

Auto/manual
- auto_en=0: K_*=man_K_* registered (1-cycle latency). The FSM keeps running, but UPDATE does not drive K_*; upd_o is suppressed.
- auto_en 0→1: K_* hold the last manual values until the next UPDATE.

Decomposition:
- Shared package wb_pkg:
  - color codes RED=0, GREEN=1, BLUE=2;
  - gain unity constant GAIN_ONE=64;
  - FSM state enum.
- One sub-module, seq_div: parameterised restoring divider.
  - Inputs: start, dividend, divisor.
  - Outputs: quotient, done, div_by_zero.
  - Instantiated once and reused for R then B.

Test Plan:
- Reset: hold rst 2 cycles → K_*=64, upd_o=0, busy_o=0, err_o=0; assert rst mid-DIV_R → no upd_o afterwards, K_* stay 64.
- Basic gains: frame of sums R=1000, G=2000, B=4000 (G_SHIFT=0), auto_en=1 → 61 cycles after frame_end, upd_o pulse with K_R=128, K_G=64, K_B=32.
- Clamp and zero: sums R=100, G=2000, B=0 → K_R=255 (1280 clamped), K_B unchanged, err_o=1; next frame_start_i clears err_o.
- Boundary pixels: frame_start_i with valid R=200, and frame_end_i with valid G=50, both included in the sums; a second frame_end_i while busy_o=1 → only one upd_o pulse.
- Manual mode: auto_en=0, man_K_*=10/20/30 → K_*=10/20/30 one cycle later; a completed frame produces no upd_o and no K_* change.
- Saturation: feed 255-valued R pixels past 2^24 → sum_R holds 2^24-1, with no wrap.
